pulse_burst_monitor: RTL and testbench

Downstream consumer of the single-cycle registered detect pulse produced by the serial pattern detector. It performs three jobs on the pulse stream:
- stretches each pulse to a visible, retriggerable indicator;
- keeps a saturating event count;
- flags bursts, meaning at least THRESH pulses inside a WINDOW-cycle span, with a fixed-length burst flag.

---
 rtl/pulse_burst_monitor_if.sv | 27 ++
 rtl/pulse_burst_monitor.sv | 145 ++++++++++++++
 tb/tb_pulse_burst_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_burst_monitor_if.sv
// Pulse/clear stimulus and monitor outputs for pulse_burst_monitor.
//   pulse_in    : single-cycle detect pulse from the upstream detector
//   clr         : synchronous clear of the count and burst logic
//   stretch_out : stretched, retriggerable pulse indicator
//   evt_count   : saturating event count (CW bits)
//   count_sat   : high while evt_count is all ones
//   burst       : burst flag, high for HOLD cycles
interface pulse_burst_monitor_if #(
  parameter int CW = 8
);
  logic          pulse_in;
  logic          clr;
  logic          stretch_out;
  logic [CW-1:0] evt_count;
  logic          count_sat;
  logic          burst;

  modport master (
    output pulse_in, clr,
    input  stretch_out, evt_count, count_sat, burst
  );

  modport slave (
    input  pulse_in, clr,
    output stretch_out, evt_count, count_sat, burst
  );
endinterface

// File: rtl/pulse_burst_monitor.sv
// Consumer of the registered detect pulse: stretches each pulse into a
// retriggerable indicator, keeps a saturating event count and flags bursts
// of THRESH pulses inside a WINDOW-cycle span with a HOLD-cycle flag.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : slave side of pulse_burst_monitor_if (pulse_in/clr in, status out)
module pulse_burst_monitor #(
  parameter int STRETCH = 4,
  parameter int CW      = 8,
  parameter int WINDOW  = 16,
  parameter int THRESH  = 3,
  parameter int HOLD    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pulse_burst_monitor_if.slave    bus
);

  localparam int TMAX0 = (STRETCH > WINDOW) ? STRETCH : WINDOW;
  localparam int TMAX  = (TMAX0 > HOLD) ? TMAX0 : HOLD;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int HW    = $clog2(THRESH + 1);

  localparam logic [TW-1:0] T_STRETCH = TW'(STRETCH);
  // Window timer counts cycles left after the opening pulse's cycle.
  localparam logic [TW-1:0] T_WIN     = TW'(WINDOW - 1);
  localparam logic [TW-1:0] T_HOLD    = TW'(HOLD);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [HW-1:0] H_THRESH  = HW'(THRESH);

  typedef enum logic [1:0] {IDLE, WIN, BURST} state_t;

  logic          pulse, clr;
  logic [TW-1:0] str_q, str_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          burst_o;

  assign pulse = bus.pulse_in;
  assign clr   = bus.clr;

  // Stretcher: reload on every pulse, clr has no effect here.
  always_comb begin
    str_d = str_q;
    if (pulse)             str_d = T_STRETCH;
    else if (str_q != '0)  str_d = str_q - T_ONE;
  end

  // Saturating counter; clr beats a simultaneous pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (pulse && !(&cnt_q)) cnt_d = cnt_q + CW'(1);
    sat_d = &cnt_d;
  end

  // Burst FSM next state. tmr_q holds remaining window or hold cycles.
  always_comb begin
    state_d = state_q;
    hits_d  = hits_q;
    tmr_d   = tmr_q;
    if (clr) begin
      state_d = IDLE;
      hits_d  = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pulse) begin
            if (THRESH == 1) begin
              state_d = BURST;
              hits_d  = '0;
              tmr_d   = T_HOLD;
            end else begin
              state_d = WIN;
              hits_d  = H_ONE;
              tmr_d   = T_WIN;
            end
          end
        end
        WIN: begin
          if (pulse && (hits_q + H_ONE) == H_THRESH) begin
            state_d = BURST;
            hits_d  = '0;
            tmr_d   = T_HOLD;
          end else if (tmr_q == T_ONE) begin
            // Last window cycle: a late pulse re-opens from IDLE next cycle.
            state_d = IDLE;
            hits_d  = '0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q - T_ONE;
            if (pulse) hits_d = hits_q + H_ONE;
          end
        end
        BURST: begin
          if (tmr_q == T_ONE) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          hits_d  = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    burst_o = (state_q == BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      str_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      state_q <= IDLE;
      hits_q  <= '0;
      tmr_q   <= '0;
    end else begin
      str_q   <= str_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      state_q <= state_d;
      hits_q  <= hits_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.stretch_out = (str_q != '0);
  assign bus.evt_count   = cnt_q;
  assign bus.count_sat   = sat_q;
  assign bus.burst       = burst_o;

endmodule

// File: tb/tb_pulse_burst_monitor.sv
module tb_pulse_burst_monitor;
  localparam int STRETCH = 4;
  localparam int WINDOW  = 16;
  localparam int THRESH  = 3;
  localparam int HOLD    = 8;

  logic clk;
  logic rst;
  logic pulse_r, clr_r;

  pulse_burst_monitor_if #(.CW(8)) bus8 ();
  pulse_burst_monitor_if #(.CW(4)) bus4 ();

  assign bus8.pulse_in = pulse_r;
  assign bus8.clr      = clr_r;
  assign bus4.pulse_in = pulse_r;
  assign bus4.clr      = clr_r;

  pulse_burst_monitor #(.STRETCH(STRETCH), .CW(8), .WINDOW(WINDOW),
                        .THRESH(THRESH), .HOLD(HOLD))
    dut8 (.clk(clk), .rst(rst), .bus(bus8));

  pulse_burst_monitor #(.STRETCH(STRETCH), .CW(4), .WINDOW(WINDOW),
                        .THRESH(THRESH), .HOLD(HOLD))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: absolute cycle times rather than countdown timers.
  int m_cyc       = 0;
  int m_last      = -1000;  // cycle of the most recent pulse
  int m_cnt8      = 0;
  int m_cnt4      = 0;
  bit m_win_open  = 0;
  int m_win_start = 0;
  int m_hits      = 0;
  int m_bend      = -1;     // last cycle burst is high

  task automatic model_step(input bit r, input bit p, input bit c);
    bit in_burst;
    if (r) begin
      m_last = -1000; m_cnt8 = 0; m_cnt4 = 0;
      m_win_open = 0; m_hits = 0; m_bend = -1;
    end else begin
      if (p) m_last = m_cyc;
      if (c) begin
        m_cnt8 = 0; m_cnt4 = 0;
      end else if (p) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt4 < 15)  m_cnt4++;
      end
      in_burst = (m_cyc <= m_bend);
      if (c) begin
        m_win_open = 0; m_hits = 0; m_bend = -1;
      end else if (!in_burst) begin
        if (m_win_open && m_cyc > m_win_start + WINDOW - 1) m_win_open = 0;
        if (p) begin
          if (!m_win_open) begin
            m_win_open = 1; m_win_start = m_cyc; m_hits = 1;
          end else begin
            m_hits++;
          end
          if (m_hits >= THRESH) begin
            m_bend = m_cyc + HOLD;
            m_win_open = 0;
          end
        end
      end
    end
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit p, input bit c);
    rst = r; pulse_r = p; clr_r = c;
    @(posedge clk);
    model_step(r, p, c);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_stretch8", int'(bus8.stretch_out), int'((m_cyc - m_last) <= STRETCH));
    chk("m_count8",   int'(bus8.evt_count),   m_cnt8);
    chk("m_sat8",     int'(bus8.count_sat),   int'(m_cnt8 == 255));
    chk("m_burst8",   int'(bus8.burst),       int'(m_cyc <= m_bend));
    chk("m_stretch4", int'(bus4.stretch_out), int'((m_cyc - m_last) <= STRETCH));
    chk("m_count4",   int'(bus4.evt_count),   m_cnt4);
    chk("m_sat4",     int'(bus4.count_sat),   int'(m_cnt4 == 15));
    chk("m_burst4",   int'(bus4.burst),       int'(m_cyc <= m_bend));
  endtask

  typedef struct {
    bit r, p, c;
    bit es;
    int ec;
    bit eb;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // {rst, pulse, clr, stretch, count, burst} seen after that cycle's edge
    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 2, 0};
    tbl[5]  = '{0, 0, 0, 1, 2, 0};
    tbl[6]  = '{0, 0, 0, 1, 2, 0};
    tbl[7]  = '{0, 0, 0, 1, 2, 0};
    tbl[8]  = '{0, 0, 0, 0, 2, 0};
    tbl[9]  = '{0, 1, 0, 1, 3, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 1, 0};

    rst = 1'b1; pulse_r = 1'b0; clr_r = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].p, tbl[i].c);
      chk("tbl_stretch", int'(bus8.stretch_out), int'(tbl[i].es));
      chk("tbl_count",   int'(bus8.evt_count),   tbl[i].ec);
      chk("tbl_sat",     int'(bus8.count_sat),   0);
      chk("tbl_burst",   int'(bus8.burst),       int'(tbl[i].eb));
    end

    // Pulses at 0,5,15: third hit on last window cycle -> burst 16..23.
    step(1, 0, 0);
    for (int t = 0; t < 26; t++) begin
      step(0, (t == 0 || t == 5 || t == 15), 0);
      chk("s4_burst", int'(bus8.burst), int'(t + 1 >= 16 && t + 1 <= 23));
    end

    // Pulses at 0,5,16: window expired, 16 starts a new one; 20,22 complete it.
    step(1, 0, 0);
    for (int t = 0; t < 24; t++) begin
      step(0, (t == 0 || t == 5 || t == 16 || t == 20 || t == 22), 0);
      chk("s4b_burst", int'(bus8.burst), int'(t >= 22));
    end

    // Reset mid-burst and mid-stretch at cycle 18.
    step(1, 0, 0);
    for (int t = 0; t < 18; t++) step(0, (t == 0 || t == 5 || t == 15), 0);
    chk("s6_pre_burst", int'(bus8.burst), 1);
    step(1, 0, 0);
    chk("s6_stretch", int'(bus8.stretch_out), 0);
    chk("s6_count",   int'(bus8.evt_count),   0);
    chk("s6_sat",     int'(bus8.count_sat),   0);
    chk("s6_burst",   int'(bus8.burst),       0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("s6_fresh_stretch", int'(bus8.stretch_out), 1);
    chk("s6_fresh_count",   int'(bus8.evt_count),   1);
    for (int t = 21; t <= 24; t++) begin
      step(0, (t == 22 || t == 24), 0);
      chk("s6_fresh_burst", int'(bus8.burst), int'(t == 24));
    end

    // Saturation on the 4-bit counter, then clr beats a simultaneous pulse.
    step(1, 0, 0);
    for (int t = 0; t < 20; t++) step(0, 1, 0);
    chk("s5_count4", int'(bus4.evt_count), 15);
    chk("s5_sat4",   int'(bus4.count_sat), 1);
    chk("s5_count8", int'(bus8.evt_count), 20);
    chk("s5_sat8",   int'(bus8.count_sat), 0);
    step(0, 1, 1);
    chk("s5_clr_count4", int'(bus4.evt_count), 0);
    chk("s5_clr_sat4",   int'(bus4.count_sat), 0);
    chk("s5_clr_count8", int'(bus8.evt_count), 0);
    chk("s5_clr_burst",  int'(bus8.burst),     0);

    // Randomized stimulus with varying pulse density.
    for (int t = 0; t < 4000; t++) begin
      int dens;
      dens = ((t / 300) % 3 == 0) ? 2 : (((t / 300) % 3 == 1) ? 6 : 12);
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, dens - 1) == 0),
           ($urandom_range(0, 79) == 0));
      chk_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
